// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register-file write-port arbiter (ALU priority, buffered load returns, stale-load kill)
//
// Merges the unstallable ALU writeback and a FIFO-buffered load-return stream
// onto the single register-file write port. A buffered load whose {thread,
// register} is overwritten by a newer ALU write is marked stale and later
// dropped at the FIFO head without writing.
//
// Ports:
//   clk, clr                 clock; asynchronous active-high reset
//   alu_valid/thread/addr/data   ALU writeback request, always served this cycle
//   mem_valid/thread/addr/data   load-return request; accepted when mem_ready
//   mem_ready                FIFO has a free slot (from registered occupancy)
//   wena/thread_wr/waddr/wdata   registered register-file write port
//   fifo_count               current FIFO occupancy
//   kill_count               saturating count of stale entries discarded

module rf_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int AW         = 5,
    parameter int TW         = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          alu_valid,
    input  logic [TW-1:0]                 alu_thread,
    input  logic [AW-1:0]                 alu_addr,
    input  logic [DATA_W-1:0]             alu_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [TW-1:0]                 mem_thread,
    input  logic [AW-1:0]                 mem_addr,
    input  logic [DATA_W-1:0]             mem_data,
    output logic                          wena,
    output logic [TW-1:0]                 thread_wr,
    output logic [AW-1:0]                 waddr,
    output logic [DATA_W-1:0]             wdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]              kill_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [TW-1:0]     thr_q  [FIFO_DEPTH];
    logic [TW-1:0]     thr_d  [FIFO_DEPTH];
    logic [AW-1:0]     addr_q [FIFO_DEPTH];
    logic [AW-1:0]     addr_d [FIFO_DEPTH];
    logic [DATA_W-1:0] data_q [FIFO_DEPTH];
    logic [DATA_W-1:0] data_d [FIFO_DEPTH];
    logic              kill_q [FIFO_DEPTH];
    logic              kill_d [FIFO_DEPTH];

    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CNT_W-1:0]  kill_cnt_q, kill_cnt_d;

    logic              wena_q, wena_d;
    logic [TW-1:0]     thread_wr_q, thread_wr_d;
    logic [AW-1:0]     waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              head_valid;
    logic              head_kill;
    logic              push;
    logic              pop_kill;
    logic              pop_write;
    logic              pop;
    logic [TW+AW-1:0]  alu_idx;

    assign mem_ready  = (count_q < CW'(FIFO_DEPTH));
    assign head_valid = (count_q != '0);
    assign head_kill  = kill_q[rd_ptr_q];
    assign push       = mem_valid && mem_ready;
    // A stale head is discarded even while the ALU owns the write port,
    // since discarding it needs no port.
    assign pop_kill   = head_valid && head_kill;
    assign pop_write  = head_valid && !head_kill && !alu_valid;
    assign pop        = pop_kill || pop_write;
    assign alu_idx    = {alu_thread, alu_addr};

    always_comb begin
        thr_d       = thr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        kill_d      = kill_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        kill_cnt_d  = kill_cnt_q;
        wena_d      = 1'b0;
        thread_wr_d = thread_wr_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;

        if (alu_valid) begin
            wena_d      = 1'b1;
            thread_wr_d = alu_thread;
            waddr_d     = alu_addr;
            wdata_d     = alu_data;
        end else if (pop_write) begin
            wena_d      = 1'b1;
            thread_wr_d = thr_q[rd_ptr_q];
            waddr_d     = addr_q[rd_ptr_q];
            wdata_d     = data_q[rd_ptr_q];
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (pop_kill && (kill_cnt_q != '1)) begin
            kill_cnt_d = kill_cnt_q + CNT_W'(1);
        end

        // Marking free slots too is harmless: a push always rewrites the
        // kill bit of the slot it fills.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (alu_valid && ({thr_q[i], addr_q[i]} == alu_idx)) begin
                kill_d[i] = 1'b1;
            end
        end

        // A load pushed alongside a matching ALU write is older in program
        // order, so it is born stale.
        if (push) begin
            thr_d[wr_ptr_q]  = mem_thread;
            addr_d[wr_ptr_q] = mem_addr;
            data_d[wr_ptr_q] = mem_data;
            kill_d[wr_ptr_q] = alu_valid && ({mem_thread, mem_addr} == alu_idx);
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end

        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                thr_q[i]  <= '0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
                kill_q[i] <= 1'b0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            kill_cnt_q  <= '0;
            wena_q      <= 1'b0;
            thread_wr_q <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            thr_q       <= thr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            kill_q      <= kill_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            kill_cnt_q  <= kill_cnt_d;
            wena_q      <= wena_d;
            thread_wr_q <= thread_wr_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign wena       = wena_q;
    assign thread_wr  = thread_wr_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign fifo_count = count_q;
    assign kill_count = kill_cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - self-checking bench for rf_write_arbiter

module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        clr;
    logic        alu_valid;
    logic [1:0]  alu_thread;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [1:0]  mem_thread;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        wena;
    logic [1:0]  thread_wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  fifo_count;
    logic [7:0]  kill_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  t;
        logic [4:0]  a;
        logic [31:0] d;
        bit          k;
    } ent_t;

    ent_t        mq[$];
    int          m_kills;
    bit          exp_wena;
    logic [1:0]  exp_thr;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;

    rf_write_arbiter dut (
        .clk        (clk),
        .clr        (clr),
        .alu_valid  (alu_valid),
        .alu_thread (alu_thread),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_thread (mem_thread),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .wena       (wena),
        .thread_wr  (thread_wr),
        .waddr      (waddr),
        .wdata      (wdata),
        .fifo_count (fifo_count),
        .kill_count (kill_count)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        mq.delete();
        m_kills  = 0;
        exp_wena = 1'b0;
        exp_thr  = '0;
        exp_addr = '0;
        exp_data = '0;
    endtask

    // One clock: drive inputs, advance the queue-level model, sample 1 time unit after the edge.
    task automatic cyc(input bit av, input logic [1:0] at, input logic [4:0] aa, input logic [31:0] ad,
                       input bit mv, input logic [1:0] mt, input logic [4:0] ma, input logic [31:0] md);
        ent_t e;
        bit   acc;
        alu_valid = av; alu_thread = at; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_thread = mt; mem_addr = ma; mem_data = md;
        acc = mv && (mq.size() < 4);
        exp_wena = 1'b0;
        if (mq.size() > 0 && mq[0].k) begin
            void'(mq.pop_front());
            if (m_kills != 255) m_kills++;
        end else if (!av && mq.size() > 0) begin
            e = mq.pop_front();
            exp_wena = 1'b1; exp_thr = e.t; exp_addr = e.a; exp_data = e.d;
        end
        if (av) begin
            exp_wena = 1'b1; exp_thr = at; exp_addr = aa; exp_data = ad;
            for (int i = 0; i < mq.size(); i++)
                if (mq[i].t == at && mq[i].a == aa) mq[i].k = 1'b1;
        end
        if (acc) begin
            e.t = mt; e.a = ma; e.d = md; e.k = av && (at == mt) && (aa == ma);
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 2'd0, 5'd0, 32'd0, 1'b0, 2'd0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        clr = 1'b1;
        alu_valid = 1'b0; alu_thread = '0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_thread = '0; mem_addr = '0; mem_data = '0;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        model_clear();
        idle();
        idle();
        total++; if (wena !== 1'b0) begin bad++; $display("FAIL reset_wena: got %b want 0", wena); end
        total++; if ({thread_wr, waddr, wdata} !== '0) begin bad++; $display("FAIL reset_port: got %h/%h/%h want 0", thread_wr, waddr, wdata); end
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", mem_ready); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        total++; if (kill_count !== 8'd0) begin bad++; $display("FAIL reset_kills: got %0d want 0", kill_count); end
    endtask

    task automatic test_alu_write();
        cyc(1'b1, 2'd2, 5'd5, 32'hDEADBEEF, 1'b0, 2'd0, 5'd0, 32'd0);
        total++; if (wena !== 1'b1) begin bad++; $display("FAIL alu_wena: got %b want 1", wena); end
        total++; if (thread_wr !== 2'd2 || waddr !== 5'd5) begin bad++; $display("FAIL alu_idx: got %0d:%0d want 2:5", thread_wr, waddr); end
        total++; if (wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL alu_data: got %h want deadbeef", wdata); end
        idle();
        total++; if (wena !== 1'b0 || wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL alu_hold: got wena=%b data=%h want 0/deadbeef", wena, wdata); end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 6; k++) begin
            total++; if (mem_ready !== (k < 4)) begin bad++; $display("FAIL bp_ready%0d: got %b want %b", k, mem_ready, (k < 4)); end
            cyc(1'b1, 2'd3, 5'(20 + k), 32'hA000 + 32'(k), (k < 5), 2'd0, 5'(k), 32'h100 + 32'(k));
            total++; if (wena !== 1'b1 || waddr !== 5'(20 + k) || wdata !== 32'hA000 + 32'(k)) begin
                bad++; $display("FAIL bp_alu%0d: got %b/%0d/%h want 1/%0d/%h", k, wena, waddr, wdata, 20 + k, 32'hA000 + 32'(k));
            end
        end
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL bp_full: got %0d want 4", fifo_count); end
        for (int j = 0; j < 4; j++) begin
            idle();
            total++; if (wena !== 1'b1 || thread_wr !== 2'd0 || waddr !== 5'(j) || wdata !== 32'h100 + 32'(j)) begin
                bad++; $display("FAIL bp_drain%0d: got %b/%0d/%0d/%h want 1/0/%0d/%h", j, wena, thread_wr, waddr, wdata, j, 32'h100 + 32'(j));
            end
        end
        idle();
        total++; if (wena !== 1'b0 || fifo_count !== 3'd0) begin bad++; $display("FAIL bp_empty: got %b/%0d want 0/0", wena, fifo_count); end
    endtask

    task automatic test_stale_kill();
        cyc(1'b0, 2'd0, 5'd0, 32'd0, 1'b1, 2'd1, 5'd3, 32'h11);
        total++; if (wena !== 1'b0 || fifo_count !== 3'd1) begin bad++; $display("FAIL stale_push: got %b/%0d want 0/1", wena, fifo_count); end
        cyc(1'b1, 2'd1, 5'd3, 32'h22, 1'b0, 2'd0, 5'd0, 32'd0);
        total++; if (wena !== 1'b1 || wdata !== 32'h22) begin bad++; $display("FAIL stale_alu: got %b/%h want 1/22", wena, wdata); end
        idle();
        total++; if (wena !== 1'b0 || wdata !== 32'h22) begin bad++; $display("FAIL stale_nowrite: got %b/%h want 0/22", wena, wdata); end
        total++; if (kill_count !== 8'd1 || fifo_count !== 3'd0) begin bad++; $display("FAIL stale_kill: got %0d/%0d want 1/0", kill_count, fifo_count); end
    endtask

    task automatic test_same_cycle_kill();
        cyc(1'b1, 2'd0, 5'd7, 32'h5, 1'b1, 2'd0, 5'd7, 32'hABC);
        total++; if (wena !== 1'b1 || wdata !== 32'h5 || fifo_count !== 3'd1) begin bad++; $display("FAIL same_alu: got %b/%h/%0d want 1/5/1", wena, wdata, fifo_count); end
        idle();
        total++; if (wena !== 1'b0 || kill_count !== 8'd2 || fifo_count !== 3'd0) begin
            bad++; $display("FAIL same_kill: got %b/%0d/%0d want 0/2/0", wena, kill_count, fifo_count);
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int k = 0; k < 3; k++)
            cyc(1'b1, 2'd2, 5'(k), 32'h300 + 32'(k), 1'b1, 2'd1, 5'(10 + k), 32'h400 + 32'(k));
        total++; if (wena !== 1'b1 || fifo_count !== 3'd3) begin bad++; $display("FAIL mid_pre: got %b/%0d want 1/3", wena, fifo_count); end
        clr = 1'b1;
        #1;
        total++; if (wena !== 1'b0 || fifo_count !== 3'd0 || kill_count !== 8'd0 || mem_ready !== 1'b1 || wdata !== 32'd0) begin
            bad++; $display("FAIL mid_clr: got %b/%0d/%0d/%b/%h want 0/0/0/1/0", wena, fifo_count, kill_count, mem_ready, wdata);
        end
        @(posedge clk);
        #1 clr = 1'b0;
        model_clear();
        for (int k = 0; k < 6; k++) begin
            idle();
            total++; if (wena !== 1'b0) begin bad++; $display("FAIL mid_ghost%0d: got %b want 0", k, wena); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            total++; if (mem_ready !== (mq.size() < 4)) begin bad++; $display("FAIL rnd_ready@%0d: got %b want %b", n, mem_ready, (mq.size() < 4)); end
            cyc(($urandom_range(0, 1) == 1), 2'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                ($urandom_range(0, 4) < 3), 2'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
            total++; if (wena !== exp_wena || thread_wr !== exp_thr || waddr !== exp_addr || wdata !== exp_data) begin
                bad++; $display("FAIL rnd_port@%0d: got %b/%0d/%0d/%h want %b/%0d/%0d/%h", n, wena, thread_wr, waddr, wdata, exp_wena, exp_thr, exp_addr, exp_data);
            end
            total++; if (fifo_count !== 3'(mq.size()) || kill_count !== 8'(m_kills)) begin
                bad++; $display("FAIL rnd_state@%0d: got %0d/%0d want %0d/%0d", n, fifo_count, kill_count, mq.size(), m_kills);
            end
        end
        repeat (6) idle();
    endtask

    task automatic test_saturate();
        for (int n = 0; n < 270; n++)
            cyc(1'b1, 2'd0, 5'd0, 32'(n), 1'b1, 2'd0, 5'd0, 32'(n));
        idle();
        total++; if (kill_count !== 8'hFF || m_kills != 255) begin bad++; $display("FAIL sat_kills: got %0d want 255", kill_count); end
        total++; if (fifo_count !== 3'd0 || wena !== 1'b0) begin bad++; $display("FAIL sat_drain: got %0d/%b want 0/0", fifo_count, wena); end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_backpressure();
        test_stale_kill();
        test_same_cycle_kill();
        test_reset_mid_drain();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
